sprite_blit: RTL and testbench
==============================

Name: sprite_blit

Overview:
- Parametrised sprite renderer for the VGA adapter path. It draws a SPR_W x SPR_H bitmap from an external synchronous ROM at a run-time (x, y) origin.
- Handshake is start/busy/done, with optional horizontal mirroring.
- Emits one plot strobe per pixel, with coordinates aligned to the ROM read latency.
- Replaces the per-object fixed-position drawers: exit, pellets, ghosts and Pac-Man all instantiate this block with their own ROM.

Parameters:
- SPR_W, 5, sprite width in pixels (>=1)
- SPR_H, 5, sprite height in pixels (>=1)
- X_W, 8, VGA x coordinate width
- Y_W, 7, VGA y coordinate width
- COL_W, 3, colour width
- ADDR_W, 5, ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H
- TRANSP_COL, 0, colour value treated as transparent (used only with the optional feature)

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- org_x  in  X_W  sprite origin x; latched on accepted start
- org_y  in  Y_W  sprite origin y; latched on accepted start
- hflip  in  1  mirror horizontally; latched on accepted start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last pixel is emitted
- rom_addr  out  ADDR_W  ROM address
- rom_q  in  COL_W  ROM data, valid 1 cycle after rom_addr
- vga_x  out  X_W  pixel x
- vga_y  out  Y_W  pixel y
- colour  out  COL_W  pixel colour (= rom_q)
- plot  out  1  pixel write strobe

Behaviour:
- Reset (async, resetn=0): state IDLE; busy=0, done=0, plot=0, rom_addr=0, vga_x=0, vga_y=0; column/row counters=0.
- States:
  - IDLE: on start=1, latch org_x/org_y/hflip, col=0, row=0 -> DRAW.
  - DRAW: each cycle issue rom_addr = row*SPR_W + (hflip ? SPR_W-1-col : col). Advance col; when col==SPR_W-1, col=0 and row++. On the last pixel (col==SPR_W-1 and row==SPR_H-1) -> FLUSH.
  - FLUSH: one cycle, drains the final ROM read -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Pipeline: the address is issued in cycle n. In cycle n+1:
  - plot=1
  - colour=rom_q
  - vga_x = org_x + col_n, vga_y = org_y + row_n, where col_n/row_n are the counter values registered from cycle n
- Counts and latency:
  - Exactly SPR_W*SPR_H plot pulses per draw, in row-major order.
  - The first plot comes 2 cycles after start is accepted.
  - done is asserted on the cycle after the last plot.
  - Total latency from start to done is SPR_W*SPR_H+2 cycles.
- Coordinate arithmetic is modulo 2^X_W / 2^Y_W. Wrap past the screen edge is not clipped; the caller keeps the origin in range.
- The address multiply is computed as a constant multiply, truncated to ADDR_W.
- start while busy or in DONE: ignored. No queueing.
- start in the same cycle that done is high: ignored; the caller re-asserts next cycle.
- Input changes on org_x/org_y/hflip during a draw have no effect.
- resetn low mid-draw: immediate abort to IDLE, no done pulse.
- SPR_W=1 or SPR_H=1 are legal degenerate cases.
- busy is low in IDLE and high in DRAW, FLUSH and DONE.

Optional Feature:
- Macro: SPRITE_BLIT_TRANSP_EN.
- Defined: plot is forced to 0 for any pixel whose rom_q==TRANSP_COL. Coordinates, timing and done are unchanged, so background pixels show through.
- Undefined: every pixel plots. The TRANSP_COL parameter is ignored.

Decomposition:
- Shared package pacman_gfx_pkg holds:
  - screen constants: SCR_W=160, SCR_H=120
  - default X_W/Y_W/COL_W
  - typedef for the FSM state enum (IDLE, DRAW, FLUSH, DONE)
  - the colour typedef
- One natural sub-module: sprite_addr_gen. It holds the col/row counters, the flip mux and the address computation, and reports last-pixel.
- The top level holds the FSM, the one-stage coordinate pipeline and the plot gating.

Test Plan:
- Defaults, org=(148,110), hflip=0, ROM holds address as data: 25 plots at (148..152, 110..114) in row-major order. colour equals rom_addr from the previous cycle. done comes 27 cycles after start, exactly one pulse.
- Same test with hflip=1: first row emits colours 4,3,2,1,0 at x=148..152. Last row emits 24..20.
- start pulsed at cycles 3, 5, 10 and on the done cycle mid-draw: only one draw, 25 plots. busy stays high continuously until done.
- resetn dropped asynchronously at pixel 12 (mid-cycle): all outputs zero immediately, no done. A new start then draws a full 25 pixels.
- SPR_W=1, SPR_H=1, org=(255,127): one plot at (255,127). done 3 cycles after start.
- SPRITE_BLIT_TRANSP_EN defined, TRANSP_COL=0, ROM with 9 zero entries: 16 plot pulses. done timing is identical to the 25-pixel case.

Source files
------------

// File: rtl/pacman_gfx_pkg.sv
// Shared graphics definitions for the Pac-Man VGA path: screen size, default
// widths, the blitter FSM state type and the colour type.
package pacman_gfx_pkg;

  localparam int unsigned SCR_W     = 160;
  localparam int unsigned SCR_H     = 120;
  localparam int unsigned DEF_X_W   = 8;
  localparam int unsigned DEF_Y_W   = 7;
  localparam int unsigned DEF_COL_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StFlush,
    StDone
  } blit_state_e;

  typedef logic [DEF_COL_W-1:0] colour_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_blit_if.sv
// Bundle of the sprite blitter's handshake, ROM and pixel-output signals.
interface sprite_blit_if
  import pacman_gfx_pkg::*;
#(
  parameter int unsigned X_W    = DEF_X_W,
  parameter int unsigned Y_W    = DEF_Y_W,
  parameter int unsigned COL_W  = DEF_COL_W,
  parameter int unsigned ADDR_W = 5
);

  logic              start;
  logic [X_W-1:0]    org_x;
  logic [Y_W-1:0]    org_y;
  logic              hflip;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_addr;
  logic [COL_W-1:0]  rom_q;
  logic [X_W-1:0]    vga_x;
  logic [Y_W-1:0]    vga_y;
  logic [COL_W-1:0]  colour;
  logic              plot;

  modport master (
    output start, org_x, org_y, hflip, rom_q,
    input  busy, done, rom_addr, vga_x, vga_y, colour, plot
  );

  modport slave (
    input  start, org_x, org_y, hflip, rom_q,
    output busy, done, rom_addr, vga_x, vga_y, colour, plot
  );

endinterface

// File: rtl/sprite_addr_gen.sv
// Column/row scan counters for the sprite blitter, with horizontal flip and
// row-major ROM address generation.
module sprite_addr_gen
  import pacman_gfx_pkg::*;
#(
  parameter int unsigned SPR_W  = 5,
  parameter int unsigned SPR_H  = 5,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned ColW   = cnt_w(SPR_W),
  parameter int unsigned RowW   = cnt_w(SPR_H)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic              hflip_i,
  output logic [ColW-1:0]   col_o,
  output logic [RowW-1:0]   row_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ColW-1:0] col_q, col_d, col_eff;
  logic [RowW-1:0] row_q, row_d;
  logic            col_end, row_end;

  assign col_end = (col_q == ColW'(SPR_W - 1));
  assign row_end = (row_q == RowW'(SPR_H - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (advance_i) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Mirroring only changes which ROM column is fetched; the screen column
  // still walks left to right.
  assign col_eff = hflip_i ? ColW'(SPR_W - 1) - col_q : col_q;
  assign addr_o  = ADDR_W'(row_q) * ADDR_W'(SPR_W) + ADDR_W'(col_eff);
  assign last_o  = col_end && row_end;
  assign col_o   = col_q;
  assign row_o   = row_q;

endmodule

// File: rtl/sprite_blit.sv
// Sprite renderer: draws an SPR_W x SPR_H bitmap from a synchronous ROM at a
// latched origin. Optional transparency via macro SPRITE_BLIT_TRANSP_EN.
module sprite_blit
  import pacman_gfx_pkg::*;
#(
  parameter int unsigned SPR_W      = 5,
  parameter int unsigned SPR_H      = 5,
  parameter int unsigned X_W        = DEF_X_W,
  parameter int unsigned Y_W        = DEF_Y_W,
  parameter int unsigned COL_W      = DEF_COL_W,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned TRANSP_COL = 0
) (
  input logic         clk,
  input logic         resetn,
  sprite_blit_if.slave bus
);

  localparam int unsigned ColW = cnt_w(SPR_W);
  localparam int unsigned RowW = cnt_w(SPR_H);

`ifdef SPRITE_BLIT_TRANSP_EN
  localparam bit TranspEn = 1'b1;
`else
  localparam bit TranspEn = 1'b0;
`endif

  blit_state_e state_q, state_d;
  logic [X_W-1:0]    org_x_q, vga_x_q, vga_x_d;
  logic [Y_W-1:0]    org_y_q, vga_y_q, vga_y_d;
  logic              hflip_q, plot_q, plot_d;
  logic              latch, clear, advance, last;
  logic [ColW-1:0]   col;
  logic [RowW-1:0]   row;
  logic [ADDR_W-1:0] addr;
  logic              pix_transp;

  sprite_addr_gen #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H),
    .ADDR_W(ADDR_W),
    .ColW  (ColW),
    .RowW  (RowW)
  ) u_addr_gen (
    .clk_i    (clk),
    .rst_ni   (resetn),
    .clear_i  (clear),
    .advance_i(advance),
    .hflip_i  (hflip_q),
    .col_o    (col),
    .row_o    (row),
    .addr_o   (addr),
    .last_o   (last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      org_x_q <= '0;
      org_y_q <= '0;
      hflip_q <= 1'b0;
      plot_q  <= 1'b0;
      vga_x_q <= '0;
      vga_y_q <= '0;
    end else begin
      state_q <= state_d;
      plot_q  <= plot_d;
      vga_x_q <= vga_x_d;
      vga_y_q <= vga_y_d;
      if (latch) begin
        org_x_q <= bus.org_x;
        org_y_q <= bus.org_y;
        hflip_q <= bus.hflip;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    clear   = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          latch   = 1'b1;
          clear   = 1'b1;
          state_d = StDraw;
        end
      end
      StDraw: begin
        advance = 1'b1;
        if (last) state_d = StFlush;
      end
      StFlush: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // One-stage pipeline so coordinates line up with the ROM's read latency.
  always_comb begin
    plot_d  = (state_q == StDraw);
    vga_x_d = vga_x_q;
    vga_y_d = vga_y_q;
    if (state_q == StDraw) begin
      vga_x_d = org_x_q + X_W'(col);
      vga_y_d = org_y_q + Y_W'(row);
    end
  end

  assign pix_transp   = (bus.rom_q == COL_W'(TRANSP_COL));
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.rom_addr = (state_q == StDraw) ? addr : '0;
  assign bus.vga_x    = vga_x_q;
  assign bus.vga_y    = vga_y_q;
  assign bus.colour   = bus.rom_q;
  assign bus.plot     = plot_q & (~TranspEn | ~pix_transp);

endmodule

// File: tb/tb_sprite_blit.sv
// Directed bench for sprite_blit: 5x5 draws (plain, mirrored, start spam,
// mid-draw reset, transparency ROM) and a 1x1 draw at the screen corner.
module tb_sprite_blit;

`ifdef SPRITE_BLIT_TRANSP_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  int   zero_lim = 0;

  always #5 clk = ~clk;

  sprite_blit_if #(.X_W(8), .Y_W(7), .COL_W(5), .ADDR_W(5)) bus0 ();
  sprite_blit_if #(.X_W(8), .Y_W(7), .COL_W(5), .ADDR_W(1)) bus1 ();

  sprite_blit #(
    .SPR_W(5), .SPR_H(5), .X_W(8), .Y_W(7), .COL_W(5), .ADDR_W(5), .TRANSP_COL(0)
  ) dut0 (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus0)
  );

  sprite_blit #(
    .SPR_W(1), .SPR_H(1), .X_W(8), .Y_W(7), .COL_W(5), .ADDR_W(1), .TRANSP_COL(0)
  ) dut1 (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus1)
  );

  // Synchronous ROMs: rom0 returns its address, except the first zero_lim words read 0.
  always @(posedge clk) begin
    bus0.rom_q <= (int'(bus0.rom_addr) < zero_lim) ? 5'd0 : bus0.rom_addr;
    bus1.rom_q <= 5'd3 + 5'(bus1.rom_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int addr_of(input int p, input bit flip);
    int c;
    c = p % 5;
    return (p / 5) * 5 + (flip ? 4 - c : c);
  endfunction

  // Full 5x5 draw, checked cycle by cycle; spam adds ignored starts and input changes.
  task automatic draw(input int ox, input int oy, input bit flip, input int zl, input bit spam);
    int plots, exp_plots, p, a, col;
    plots = 0;
    exp_plots = 0;
    @(negedge clk);
    zero_lim   = zl;
    bus0.org_x = 8'(ox);
    bus0.org_y = 7'(oy);
    bus0.hflip = flip;
    bus0.start = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      bus0.start = 1'b0;
      chk("busy", bus0.busy, (k <= 27) ? 1 : 0);
      chk("done", bus0.done, (k == 27) ? 1 : 0);
      if (k <= 25) chk("rom_addr", bus0.rom_addr, addr_of(k - 1, flip));
      if (k >= 2 && k <= 26) begin
        p   = k - 2;
        a   = addr_of(p, flip);
        col = (a < zl) ? 0 : a;
        chk("vga_x", bus0.vga_x, (ox + p % 5) % 256);
        chk("vga_y", bus0.vga_y, (oy + p / 5) % 128);
        chk("colour", bus0.colour, col);
        chk("plot", bus0.plot, (TRANSP && col == 0) ? 0 : 1);
        if (!(TRANSP && col == 0)) exp_plots++;
      end else begin
        chk("plot_idle", bus0.plot, 0);
      end
      if (bus0.plot) plots++;
      if (spam && (k == 3 || k == 5 || k == 10 || k == 27)) bus0.start = 1'b1;
      if (spam && k == 5) begin
        bus0.org_x = 8'd0;
        bus0.org_y = 7'd0;
        bus0.hflip = ~flip;
      end
    end
    chk("plot_count", plots, exp_plots);
  endtask

  initial begin
    int dones;
    resetn = 1'b0;
    bus0.start = 1'b0; bus0.org_x = '0; bus0.org_y = '0; bus0.hflip = 1'b0;
    bus1.start = 1'b0; bus1.org_x = '0; bus1.org_y = '0; bus1.hflip = 1'b0;
    #2;
    chk("rst_busy", bus0.busy, 0);
    chk("rst_done", bus0.done, 0);
    chk("rst_plot", bus0.plot, 0);
    chk("rst_addr", bus0.rom_addr, 0);
    chk("rst_x", bus0.vga_x, 0);
    chk("rst_y", bus0.vga_y, 0);
    chk("rst_busy1", bus1.busy, 0);
    @(negedge clk);
    resetn = 1'b1;

    draw(148, 110, 1'b0, 0, 1'b0);
    draw(148, 110, 1'b1, 0, 1'b0);
    draw(30, 40, 1'b0, 0, 1'b1);

    // Abort mid-draw, just after pixel 12 has been plotted.
    @(negedge clk);
    zero_lim = 0;
    bus0.org_x = 8'd148; bus0.org_y = 7'd110; bus0.hflip = 1'b0;
    bus0.start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      bus0.start = 1'b0;
    end
    chk("pre_abort_x", bus0.vga_x, 150);
    chk("pre_abort_y", bus0.vga_y, 112);
    #2 resetn = 1'b0;
    #1;
    chk("abort_busy", bus0.busy, 0);
    chk("abort_done", bus0.done, 0);
    chk("abort_plot", bus0.plot, 0);
    chk("abort_addr", bus0.rom_addr, 0);
    chk("abort_x", bus0.vga_x, 0);
    chk("abort_y", bus0.vga_y, 0);
    @(negedge clk);
    resetn = 1'b1;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus0.done || bus0.busy) dones++;
    end
    chk("abort_quiet", dones, 0);
    draw(0, 0, 1'b1, 0, 1'b0);

    // Nine transparent-colour words at the start of the ROM.
    draw(10, 20, 1'b0, 9, 1'b0);
    zero_lim = 0;

    // 1x1 sprite at the far corner.
    @(negedge clk);
    bus1.org_x = 8'd255; bus1.org_y = 7'd127; bus1.hflip = 1'b0;
    bus1.start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus1.start = 1'b0;
      chk("s1_busy", bus1.busy, (k <= 3) ? 1 : 0);
      chk("s1_done", bus1.done, (k == 3) ? 1 : 0);
      chk("s1_plot", bus1.plot, (k == 2) ? 1 : 0);
      if (k == 1) chk("s1_addr", bus1.rom_addr, 0);
      if (k == 2) begin
        chk("s1_x", bus1.vga_x, 255);
        chk("s1_y", bus1.vga_y, 127);
        chk("s1_colour", bus1.colour, 3);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
